fft_peak_detect: RTL and testbench

- Downstream consumer of the FFT core's serial output stream.
- Each frame delivers bins 0..N-1 in natural order. The block computes the power |X[k]|^2 = re^2 + im^2 for bins 0..N/2-1, tracks the maximum, and reports the peak bin index and power once per frame.
- Intended hookup: in_valid = FFT done, in_data = FFT wd, frame_start = FFT start.

---
 rtl/fft_peak_detect_if.sv | 24 ++
 rtl/fft_peak_detect.sv | 132 +++++++++++++
 tb/tb_fft_peak_detect.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_detect_if.sv
// Bundles the FFT output stream and the peak report for fft_peak_detect.
// The bench drives through master; the detector uses slave.
interface fft_peak_detect_if #(
   parameter int width = 16,
   parameter int N_2   = 5
);
   logic                 frame_start;
   logic                 in_valid;
   logic [2*width-1:0]   in_data;
   logic [N_2-2:0]       peak_idx;
   logic [2*width-1:0]   peak_mag;
   logic                 result_valid;
   logic                 busy;

   modport master (
      output frame_start, in_valid, in_data,
      input  peak_idx, peak_mag, result_valid, busy
   );

   modport slave (
      input  frame_start, in_valid, in_data,
      output peak_idx, peak_mag, result_valid, busy
   );
endinterface

// File: rtl/fft_peak_detect.sv
// Finds the max-power bin in the lower half of each FFT frame and reports it once per frame.
// Define FFT_PEAK_DC_SKIP_EN to exclude bin 0 (DC) from the search.
//
// state   | meaning
// COLLECT | bins 0..N/2-1 arriving; samples enter the power pipeline
// DISCARD | bins N/2..N-1 arriving; samples counted and dropped
module fft_peak_detect #(
   parameter int width = 16,
   parameter int N_2   = 5
) (
   input  logic              clk,
   input  logic              reset,
   fft_peak_detect_if.slave  bus
);
   localparam int N = 2**N_2;
   localparam logic [N_2-1:0] LAST_LO = N_2'(N/2 - 1);
   localparam logic [N_2-1:0] LAST_HI = N_2'(N - 1);

   typedef enum logic {COLLECT, DISCARD} state_t;

   state_t                   state, state_eff, state_nxt;
   logic [N_2-1:0]           bin_cnt, cnt_eff, cnt_nxt;
   logic                     take;

   logic signed [width-1:0]  in_re, in_im;
   logic signed [2*width-1:0] re_x, im_x, re2, im2;

   logic                     s1_vld, s1_last;
   logic signed [2*width-1:0] s1_re2, s1_im2;
   logic [N_2-2:0]           s1_idx;

   logic [2*width-1:0]       sum, run_max, max_nxt;
   logic [N_2-2:0]           run_idx, idx_nxt;
   logic                     consider, first, upd;

   logic [N_2-2:0]           peak_idx_r;
   logic [2*width-1:0]       peak_mag_r;
   logic                     result_valid_r, busy_r;

   assign in_re = bus.in_data[2*width-1:width];
   assign in_im = bus.in_data[width-1:0];
   assign re_x  = {{width{in_re[width-1]}}, in_re};
   assign im_x  = {{width{in_im[width-1]}}, in_im};
   // Squares of width-bit values always fit in 2*width bits.
   assign re2   = re_x * re_x;
   assign im2   = im_x * im_x;

   // A frame_start cycle behaves as if the counter were already at bin 0.
   always_comb begin
      cnt_eff   = bus.frame_start ? '0 : bin_cnt;
      state_eff = bus.frame_start ? COLLECT : state;
      state_nxt = state_eff;
      cnt_nxt   = cnt_eff;
      take      = 1'b0;
      if (bus.in_valid) begin
         cnt_nxt = cnt_eff + 1'b1;
         case (state_eff)
            COLLECT: begin
               take = 1'b1;
               if (cnt_eff == LAST_LO) state_nxt = DISCARD;
            end
            DISCARD: begin
               if (cnt_eff == LAST_HI) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
         endcase
      end
   end

   always_comb begin
      sum = s1_re2 + s1_im2;
`ifdef FFT_PEAK_DC_SKIP_EN
      consider = s1_vld && (s1_idx != '0);
      first    = (s1_idx == (N_2-1)'(1));
`else
      consider = s1_vld;
      first    = (s1_idx == '0);
`endif
      upd     = consider && (first || (sum > run_max));
      max_nxt = upd ? sum    : run_max;
      idx_nxt = upd ? s1_idx : run_idx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= COLLECT;
         bin_cnt        <= '0;
         s1_vld         <= 1'b0;
         s1_last        <= 1'b0;
         s1_re2         <= '0;
         s1_im2         <= '0;
         s1_idx         <= '0;
         run_max        <= '0;
         run_idx        <= '0;
         peak_idx_r     <= '0;
         peak_mag_r     <= '0;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state          <= state_nxt;
         bin_cnt        <= cnt_nxt;
         s1_vld         <= take;
         result_valid_r <= 1'b0;
         if (take) begin
            s1_re2  <= re2;
            s1_im2  <= im2;
            s1_idx  <= cnt_eff[N_2-2:0];
            s1_last <= (cnt_eff == LAST_LO);
         end
         if (bus.frame_start) begin
            run_max <= '0;
            run_idx <= '0;
            busy_r  <= take;
         end else begin
            run_max <= max_nxt;
            run_idx <= idx_nxt;
            if (s1_vld && s1_last) begin
               peak_idx_r     <= idx_nxt;
               peak_mag_r     <= max_nxt;
               result_valid_r <= 1'b1;
               busy_r         <= 1'b0;
            end
            if (take && cnt_eff == '0) busy_r <= 1'b1;
         end
      end
   end

   assign bus.peak_idx     = peak_idx_r;
   assign bus.peak_mag     = peak_mag_r;
   assign bus.result_valid = result_valid_r;
   assign bus.busy         = busy_r;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: frames are built in arrays, the expected peak is
// computed directly from the bin powers and queued, and a monitor checks each result pulse.
module tb_fft_peak_detect;
   localparam int WIDTH = 16;
   localparam int N_2   = 5;
   localparam int N     = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;

   fft_peak_detect_if #(.width(WIDTH), .N_2(N_2)) bus ();

   fft_peak_detect #(.width(WIDTH), .N_2(N_2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   logic signed [WIDTH-1:0] fre [N];
   logic signed [WIDTH-1:0] fim [N];

   int     q_idx [$];
   longint q_mag [$];
   int     q_cyc [$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic longint power(input int k);
      return longint'(fre[k]) * longint'(fre[k]) + longint'(fim[k]) * longint'(fim[k]);
   endfunction

   task automatic model(output int ei, output longint em);
      int start;
`ifdef FFT_PEAK_DC_SKIP_EN
      start = 1;
`else
      start = 0;
`endif
      ei = start;
      em = power(start);
      for (int k = start + 1; k < N/2; k++) begin
         if (power(k) > em) begin
            em = power(k);
            ei = k;
         end
      end
   endtask

   task automatic clear_frame();
      for (int k = 0; k < N; k++) begin
         fre[k] = '0;
         fim[k] = '0;
      end
   endtask

   // gap_mode: 0 continuous, 1 idle after every sample, 2 random idles before samples
   task automatic send_frame(input int nbins, input int gap_mode, input bit fs_first);
      int     ei;
      longint em;
      for (int k = 0; k < nbins; k++) begin
         if (gap_mode == 2) begin
            int g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
               @(posedge clk); #1;
            end
         end
         bus.in_valid    = 1'b1;
         bus.in_data     = {fre[k], fim[k]};
         bus.frame_start = fs_first && (k == 0);
         if (k == N/2 - 1) begin
            model(ei, em);
            q_idx.push_back(ei);
            q_mag.push_back(em);
            q_cyc.push_back(cyc + 2);
         end
         @(posedge clk); #1;
         bus.in_valid    = 1'b0;
         bus.frame_start = 1'b0;
         if (gap_mode == 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic pulse_fs();
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && q_idx.size() > 0; i++) begin
         @(posedge clk);
      end
      #1;
      chk({name, "_drain"}, q_idx.size(), 0);
      @(posedge clk); #1;
      chk({name, "_busy_idle"}, bus.busy, 0);
   endtask

   always @(negedge clk) begin
      if (reset && bus.result_valid) begin
         if (q_idx.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            chk("peak_idx", bus.peak_idx, q_idx.pop_front());
            chk("peak_mag", bus.peak_mag, q_mag.pop_front());
            chk("latency", cyc, q_cyc.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.frame_start = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      #3;
      chk("rst_peak_idx", bus.peak_idx, 0);
      chk("rst_peak_mag", bus.peak_mag, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_busy", bus.busy, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      clear_frame(); fre[5] = 1000;
      send_frame(N, 0, 0);
      drain("tone");

      clear_frame(); fre[3] = 300; fim[3] = 400; fre[9] = 300; fim[9] = 400;
      send_frame(N, 0, 0);
      drain("tie");

      clear_frame(); fre[20] = 32767; fre[2] = 10; fim[2] = -10;
      send_frame(N, 0, 0);
      clear_frame(); fre[7] = -32768; fim[7] = -32768;
      send_frame(N, 0, 0);
      drain("extreme");

      clear_frame(); fre[5] = 1000;
      send_frame(N, 1, 0);
      drain("gapped");

      for (int k = 0; k < N; k++) fre[k] = 5000;
      send_frame(8, 0, 0);
      pulse_fs();
      clear_frame(); fre[4] = 50;
      send_frame(N, 0, 0);
      drain("resync");

      for (int k = 0; k < N; k++) fim[k] = -7000;
      send_frame(5, 0, 0);
      clear_frame(); fre[11] = -123; fim[11] = 77;
      send_frame(N, 2, 1);
      drain("resync_first");

      clear_frame(); fre[0] = 2000; fre[4] = 10;
      send_frame(N, 0, 0);
      drain("dc");

      clear_frame();
      send_frame(N, 0, 0);
      drain("zero");

      clear_frame(); fre[6] = 900;
      send_frame(10, 0, 0);
      chk("busy_mid", bus.busy, 1);
      reset = 1'b0;
      #2;
      chk("midrst_peak_idx", bus.peak_idx, 0);
      chk("midrst_peak_mag", bus.peak_mag, 0);
      chk("midrst_result_valid", bus.result_valid, 0);
      chk("midrst_busy", bus.busy, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      fre[6] = 900;
      send_frame(N, 0, 0);
      drain("after_reset");

      for (int f = 0; f < 20; f++) begin
         int mode = $urandom_range(0, 2);
         clear_frame();
         for (int k = 0; k < N; k++) begin
            if (mode == 0) begin
               fre[k] = 16'($urandom());
               fim[k] = 16'($urandom());
            end else if (mode == 1) begin
               int a = $urandom_range(0, 3);
               int b = $urandom_range(0, 3);
               fre[k] = 16'(a - 2);
               fim[k] = 16'(b - 2);
            end
         end
         if (mode == 2) begin
            int t = $urandom_range(0, N - 1);
            fre[t] = 16'($urandom());
            fim[t] = 16'($urandom());
         end
         send_frame(N, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      end
      drain("random");

      chk("queue_empty", q_idx.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
